avg_sequencer: RTL and testbench

//  Self-sequenced control unit for the averaging CPU datapath: bus reg X (tx), accumulator Y (ty), output reg Z (tz), ULA (tula).

---
 rtl/cpu_ctrl_pkg.sv | 25 ++
 rtl/avg_sequencer.sv | 132 +++++++++++++
 tb/tb_avg_sequencer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Control codes and sequencer state encoding shared by the averaging CPU
// datapath (bus reg X, accumulator Y, output reg Z, ULA) and its sequencer.
package cpu_ctrl_pkg;

    localparam int CTRL_CODE_W = 4;

    // Register control codes; Y LOAD means Y <= Y + X.
    localparam int unsigned CLEAR   = 0;
    localparam int unsigned LOAD    = 1;
    localparam int unsigned HOLD    = 2;
    localparam int unsigned SHIFTR  = 3;

    localparam int unsigned ULA_ADD = 0;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        FETCH,
        DRAIN,
        SHIFT,
        STORE,
        DONE
    } state_t;

endpackage

// File: rtl/avg_sequencer.sv
// Self-sequenced controller that sums N = 2**LOG2_N operands through the
// X/Y/Z datapath and optionally divides by N with LOG2_N right shifts.
module avg_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int LOG2_N = 1,
    parameter int CODE_W = CTRL_CODE_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic [CODE_W-1:0] tx,
    output logic [CODE_W-1:0] ty,
    output logic [CODE_W-1:0] tz,
    output logic [CODE_W-1:0] tula
);

    localparam int N    = 1 << LOG2_N;
    localparam int OP_W = LOG2_N + 1;
    localparam int SH_W = LOG2_N;

    localparam logic [CODE_W-1:0] C_CLEAR  = CODE_W'(CLEAR);
    localparam logic [CODE_W-1:0] C_LOAD   = CODE_W'(LOAD);
    localparam logic [CODE_W-1:0] C_HOLD   = CODE_W'(HOLD);
    localparam logic [CODE_W-1:0] C_SHIFTR = CODE_W'(SHIFTR);

    localparam logic [OP_W-1:0] OP_LAST = OP_W'(N - 1);
    localparam logic [SH_W-1:0] SH_LAST = SH_W'(LOG2_N - 1);

    state_t            state_q, state_d;
    logic [OP_W-1:0]   op_cnt_q, op_cnt_d;
    logic [SH_W-1:0]   sh_cnt_q, sh_cnt_d;
    logic              mode_q, mode_d;

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge value of its neighbours; combinational blocks use blocking.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            op_cnt_q <= '0;
            sh_cnt_q <= '0;
            mode_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_cnt_q <= op_cnt_d;
            sh_cnt_q <= sh_cnt_d;
            mode_q   <= mode_d;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statement can leave a latch behind.
    always_comb begin
        state_d  = state_q;
        op_cnt_d = op_cnt_q;
        sh_cnt_d = sh_cnt_q;
        mode_d   = mode_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLR;
                    mode_d  = mode;
                end
            end
            CLR: begin
                op_cnt_d = '0;
                state_d  = FETCH;
            end
            FETCH: begin
                if (in_valid) begin
                    op_cnt_d = op_cnt_q + 1'b1;
                    if (op_cnt_q == OP_LAST) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                sh_cnt_d = '0;
                state_d  = mode_q ? STORE : SHIFT;
            end
            SHIFT: begin
                if (sh_cnt_q == SH_LAST) begin
                    state_d = STORE;
                end else begin
                    sh_cnt_d = sh_cnt_q + 1'b1;
                end
            end
            STORE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx       = C_HOLD;
        ty       = C_HOLD;
        tz       = C_HOLD;
        in_ready = 1'b0;
        done     = 1'b0;
        busy     = (state_q != IDLE);
        unique case (state_q)
            CLR: begin
                tx = C_CLEAR;
                ty = C_CLEAR;
            end
            FETCH: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    tx = C_LOAD;
                    ty = C_LOAD;
                end
            end
            // The last operand is still sitting in X and must be folded in.
            DRAIN: begin
                tx = C_CLEAR;
                ty = C_LOAD;
            end
            SHIFT:   ty = C_SHIFTR;
            STORE:   tz = C_LOAD;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign tula = CODE_W'(ULA_ADD);

endmodule

// File: tb/tb_avg_sequencer.sv
// Scoreboard bench for avg_sequencer at LOG2_N = 1, 2, 3 with a behavioural
// X/Y/Z datapath driven by the sequencer's control codes.
module tb_avg_sequencer;
    import cpu_ctrl_pkg::*;

    localparam int CW = CTRL_CODE_W;
    localparam logic [CW-1:0] C_CLEAR  = CW'(CLEAR);
    localparam logic [CW-1:0] C_LOAD   = CW'(LOAD);
    localparam logic [CW-1:0] C_HOLD   = CW'(HOLD);
    localparam logic [CW-1:0] C_SHIFTR = CW'(SHIFTR);
    localparam logic [CW-1:0] C_ADD    = CW'(ULA_ADD);

    typedef logic [7:0] op_arr_t [8];
    typedef struct {
        logic [15:0] z;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    generate
        for (genvar g = 0; g < 3; g++) begin : u
            localparam int L = g + 1;
            localparam int N = 1 << L;

            logic            rst, start, mode, in_valid;
            logic [15:0]     data;
            logic            in_ready, busy, done;
            logic [CW-1:0]   tx, ty, tz, tula;
            logic [15:0]     x_m, y_m, z_m;
            exp_t            exp_q[$];
            bit              busy_chk = 1'b0;
            bit              fin_b = 1'b0;

            avg_sequencer #(.LOG2_N(L), .CODE_W(CW)) dut (
                .clock   (clk),
                .reset   (rst),
                .start   (start),
                .mode    (mode),
                .in_valid(in_valid),
                .in_ready(in_ready),
                .busy    (busy),
                .done    (done),
                .tx      (tx),
                .ty      (ty),
                .tz      (tz),
                .tula    (tula)
            );

            // Datapath reacting to whatever codes the sequencer presents.
            always @(posedge clk) begin
                case (tx)
                    C_CLEAR: x_m <= '0;
                    C_LOAD:  x_m <= data;
                    default: ;
                endcase
                case (ty)
                    C_CLEAR:  y_m <= '0;
                    C_LOAD:   y_m <= y_m + x_m;
                    C_SHIFTR: y_m <= y_m >> 1;
                    default:  ;
                endcase
                if (tz == C_LOAD) z_m <= y_m;
            end

            function automatic string nm(input string s);
                return $sformatf("L%0d_%s", L, s);
            endfunction

            // Monitor: every done pulse must match the oldest expected result.
            always @(negedge clk) begin
                if (busy_chk) begin
                    check(nm("busy_after_done"), busy, 0);
                    busy_chk <= 1'b0;
                end
                if (done === 1'b1) begin
                    check(nm("done_expected"), exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        check(nm("z_result"), z_m, exp_q[0].z);
                        check(nm("done_cycle"), cyc, exp_q[0].cyc);
                        exp_q.delete(0);
                    end
                    check(nm("busy_in_done"), busy, 1);
                    check(nm("tula"), tula, C_ADD);
                    busy_chk <= 1'b1;
                end
            end

            function automatic op_arr_t directed_ops();
                op_arr_t o;
                for (int i = 0; i < 8; i++) o[i] = 8'(i + 1);
                if (N == 2) begin
                    o[0] = 8'd6;
                    o[1] = 8'd10;
                end
                return o;
            endfunction

            function automatic op_arr_t random_ops();
                op_arr_t o;
                for (int i = 0; i < 8; i++) o[i] = 8'($urandom_range(255, 0));
                return o;
            endfunction

            // One run from an IDLE cycle; reset_at > 0 aborts the run in that
            // cycle (counted from the cycle start is sampled in, as cycle 0).
            task automatic run(input op_arr_t ops, input logic m, input int max_stall,
                               input int stall_idx, input bit pulse_fetch, input bit pulse_done,
                               input bit hold_start, input int reset_at);
                int e, d, k, stalls, sum;
                exp_t ex;
                @(negedge clk);
                e     = cyc;
                start = 1'b1;
                mode  = m;
                @(negedge clk);
                start = hold_start;
                mode  = ~m;
                #1;
                check(nm("in_ready_clr"), in_ready, 0);
                check(nm("busy_clr"), busy, 1);
                stalls = 0;
                sum    = 0;
                for (int i = 0; i < N; i++) begin
                    if (i == stall_idx) k = 3;
                    else if (max_stall > 0) k = int'($urandom_range(max_stall, 0));
                    else k = 0;
                    for (int s = 0; s <= k; s++) begin
                        @(negedge clk);
                        in_valid = (s == k);
                        data     = (s == k) ? 16'(ops[i]) : 16'($urandom_range(65535, 0));
                        start    = hold_start || (pulse_fetch && i == 0 && s == 0);
                        #1;
                        check(nm("in_ready_fetch"), in_ready, 1);
                        check(nm("tx_fetch"), tx, (s == k) ? C_LOAD : C_HOLD);
                        check(nm("ty_fetch"), ty, (s == k) ? C_LOAD : C_HOLD);
                    end
                    stalls += k;
                    sum    += int'(ops[i]);
                end
                @(negedge clk);
                in_valid = 1'b0;
                start    = hold_start;
                if (reset_at > 0) begin
                    while (cyc < e + reset_at + stalls) @(negedge clk);
                    rst = 1'b1;
                    #1;
                    check(nm("ty_shift_before_reset"), ty, C_SHIFTR);
                    @(negedge clk);
                    rst = 1'b0;
                    #1;
                    check(nm("busy_after_reset"), busy, 0);
                    check(nm("tx_after_reset"), tx, C_HOLD);
                    check(nm("ty_after_reset"), ty, C_HOLD);
                    check(nm("tz_after_reset"), tz, C_HOLD);
                    check(nm("done_after_reset"), done, 0);
                    repeat (L + 8) @(negedge clk);
                    check(nm("still_idle_after_reset"), busy, 0);
                    return;
                end
                d      = e + N + (m ? 0 : L) + 4 + stalls;
                ex.z   = m ? 16'(sum) : 16'(sum / N);
                ex.cyc = d;
                exp_q.push_back(ex);
                while (cyc < d) @(negedge clk);
                if (pulse_done) begin
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                    @(negedge clk);
                    #1;
                    check(nm("start_in_done_ignored"), busy, 0);
                end
            endtask

            initial begin
                op_arr_t ops;
                rst      = 1'b1;
                start    = 1'b0;
                mode     = 1'b0;
                in_valid = 1'b0;
                data     = '0;
                repeat (3) @(negedge clk);
                rst = 1'b0;
                #1;
                check(nm("reset_busy"), busy, 0);
                check(nm("reset_in_ready"), in_ready, 0);
                check(nm("reset_done"), done, 0);
                check(nm("reset_tx"), tx, C_HOLD);
                check(nm("reset_ty"), ty, C_HOLD);
                check(nm("reset_tz"), tz, C_HOLD);
                check(nm("reset_tula"), tula, C_ADD);

                ops = directed_ops();
                run(ops, 1'b0, 0, -1, 1'b0, 1'b0, 1'b0, 0);
                run(ops, 1'b1, 0, -1, 1'b0, 1'b0, 1'b0, 0);
                run(ops, 1'b0, 0, (N > 2) ? 2 : 1, 1'b1, 1'b1, 1'b0, 0);
                for (int r = 0; r < 8; r++) begin
                    ops = random_ops();
                    run(ops, 1'($urandom_range(1, 0)), 3, -1,
                        1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'b0, 0);
                end
                ops = random_ops();
                run(ops, 1'b0, 0, -1, 1'b0, 1'b0, 1'b0, N + 3 + ((L >= 2) ? 1 : 0));
                ops = directed_ops();
                run(ops, 1'b0, 0, -1, 1'b0, 1'b0, 1'b0, 0);
                for (int r = 0; r < 3; r++) begin
                    ops = random_ops();
                    run(ops, 1'($urandom_range(1, 0)), 0, -1, 1'b0, 1'b0, 1'b1, 0);
                end
                run(ops, 1'b1, 0, -1, 1'b0, 1'b0, 1'b0, 0);
                repeat (5) @(negedge clk);
                check(nm("scoreboard_empty"), exp_q.size(), 0);
                fin_b = 1'b1;
            end
        end
    endgenerate

    initial begin
        for (int t = 0; t < 20000 && !(u[0].fin_b && u[1].fin_b && u[2].fin_b); t++)
            @(negedge clk);
        check("all_instances_finished", u[0].fin_b && u[1].fin_b && u[2].fin_b, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
